// File: rtl/pipe_stage_buf.sv
// Pipeline-stage register carrying {instr, pc, wreg, result, rd2} with a
// valid/ready handshake, synchronous flush and an optional 2-entry skid buffer.
// SKID=1: registered in_ready, EMPTY/ONE/FULL FSM. SKID=0: single entry,
// in_ready passes out_ready through combinationally.
module pipe_stage_buf #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [REG_W-1:0]  in_wreg,
  input  logic [DATA_W-1:0] in_result,
  input  logic [DATA_W-1:0] in_rd2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [REG_W-1:0]  out_wreg,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_rd2,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
    logic [REG_W-1:0]  wreg;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rd2;
  } entry_t;

  entry_t in_ent, head_q, out_ent;
  logic   head_vld;
  logic   accept, retire;

  assign in_ent = '{instr: in_instr, pc: in_pc, wreg: in_wreg,
                    result: in_result, rd2: in_rd2};
  assign accept = in_valid && in_ready;
  assign retire = head_vld && out_ready;

  // Bubbles read as all-zero so wreg=0 keeps downstream hazard logic inert.
  assign out_ent    = head_vld ? head_q : '0;
  assign out_valid  = head_vld;
  assign out_instr  = out_ent.instr;
  assign out_pc     = out_ent.pc;
  assign out_wreg   = out_ent.wreg;
  assign out_result = out_ent.result;
  assign out_rd2    = out_ent.rd2;

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2} state_t;
      state_t state_q, state_d;
      entry_t skid_q;
      logic   rdy_q;

      // State register; in_ready is its own flop so it never sees out_ready combinationally.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          state_q <= S_EMPTY;
          rdy_q   <= 1'b1;
        end else begin
          state_q <= state_d;
          rdy_q   <= (state_d != S_FULL);
        end
      end

      // Next-state: flush wins over any simultaneous accept or retire.
      always_comb begin
        state_d = state_q;
        if (flush) begin
          state_d = S_EMPTY;
        end else begin
          case (state_q)
            S_EMPTY: if (accept) state_d = S_ONE;
            S_ONE: begin
              if (accept && !retire)      state_d = S_FULL;
              else if (retire && !accept) state_d = S_EMPTY;
            end
            S_FULL:  if (retire) state_d = S_ONE;
            default: state_d = S_EMPTY;
          endcase
        end
      end

      // Outputs decoded from the registered state.
      always_comb begin
        head_vld  = (state_q != S_EMPTY);
        in_ready  = rdy_q;
        occupancy = (state_q == S_FULL) ? 2'd2 : (state_q == S_ONE) ? 2'd1 : 2'd0;
      end

      // Entry storage: head is always the oldest; skid holds the younger entry when FULL.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          head_q <= '0;
          skid_q <= '0;
        end else if (!flush) begin
          case (state_q)
            S_EMPTY: if (accept) head_q <= in_ent;
            S_ONE: begin
              if (accept && retire) head_q <= in_ent;
              else if (accept)      skid_q <= in_ent;
            end
            S_FULL:  if (retire) head_q <= skid_q;
            default: ;
          endcase
        end
      end
    end else begin : g_single
      logic vld_q;

      // Single entry: accept (even with a same-cycle retire) reloads it; retire alone empties it.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_q  <= 1'b0;
          head_q <= '0;
        end else if (flush) begin
          vld_q  <= 1'b0;
        end else if (accept) begin
          vld_q  <= 1'b1;
          head_q <= in_ent;
        end else if (retire) begin
          vld_q  <= 1'b0;
        end
      end

      // Ready passes through when the held entry is leaving this cycle.
      always_comb begin
        head_vld  = vld_q;
        in_ready  = !vld_q || out_ready;
        occupancy = {1'b0, vld_q};
      end
    end
  endgenerate

endmodule
